// File: rtl/serial_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : serial_frame_rx
// Brief    : Hunts a serial bitstream for a sync word, then captures an
//            MSB-first payload plus an even-parity bit and presents framed words.
// Revision : 1.0 - initial release
// ============================================================================
module serial_frame_rx #(
  parameter logic [5:0] SYNC   = 6'b101100,
  parameter int         DATA_W = 6,
  parameter int         CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sin,
  input  logic              en,
  output logic [DATA_W-1:0] data,
  output logic              data_valid,
  output logic              parity_err,
  output logic              in_frame,
  output logic [CNT_W-1:0]  frame_cnt
);

  localparam int BCNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t             state;
  logic [5:0]         history;
  logic [2:0]         fill;
  logic [BCNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0]  payload;
  logic [5:0]         history_next;

  assign history_next = {history[4:0], sin};

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= HUNT;
      history    <= '0;
      fill       <= '0;
      bit_cnt    <= '0;
      payload    <= '0;
      data       <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      in_frame   <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      if (en) begin
        case (state)
          HUNT: begin
            history <= history_next;
            if (fill != 3'd6) fill <= fill + 3'd1;
            // fill >= 5 here means the updated window holds six real bits
            if ((fill >= 3'd5) && (history_next == SYNC)) begin
              state    <= DATA;
              bit_cnt  <= '0;
              in_frame <= 1'b1;
            end
          end
          DATA: begin
            payload <= {payload[DATA_W-2:0], sin};
            bit_cnt <= bit_cnt + BCNT_W'(1);
            if (bit_cnt == BCNT_W'(DATA_W - 1)) state <= PARITY;
          end
          PARITY: begin
            if ((^payload) == sin) begin
              data       <= payload;
              data_valid <= 1'b1;
              frame_cnt  <= frame_cnt + CNT_W'(1);
            end else begin
              parity_err <= 1'b1;
            end
            state    <= HUNT;
            history  <= '0;
            fill     <= '0;
            in_frame <= 1'b0;
          end
          default: begin
            state    <= HUNT;
            in_frame <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_frame_rx
// Brief    : Scoreboard bench for serial_frame_rx using directed frames.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_frame_rx;

  localparam int DATA_W = 6;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              sin = 1'b0;
  logic              en  = 1'b0;
  logic [DATA_W-1:0] data;
  logic              data_valid;
  logic              parity_err;
  logic              in_frame;
  logic [CNT_W-1:0]  frame_cnt;

  serial_frame_rx #(
    .SYNC   (6'b101100),
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sin        (sin),
    .en         (en),
    .data       (data),
    .data_valid (data_valid),
    .parity_err (parity_err),
    .in_frame   (in_frame),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic              good;
    logic [DATA_W-1:0] d;
    logic [CNT_W-1:0]  c;
  } exp_t;

  exp_t              q[$];
  int                checks  = 0;
  int                passed  = 0;
  int                if_high = 0;
  logic [DATA_W-1:0] m_data  = '0;
  logic [CNT_W-1:0]  m_cnt   = '0;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  // Monitor: every pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (data_valid || parity_err) begin
        if (q.size() == 0) begin
          check("unexpected_pulse", 1, 0);
        end else begin
          e = q.pop_front();
          check("pulse_kind", int'(data_valid), int'(e.good));
          check("pulse_exclusive", int'(data_valid & parity_err), 0);
          check("data", int'(data), int'(e.d));
          check("frame_cnt", int'(frame_cnt), int'(e.c));
        end
      end
    end
  end

  task automatic send_bit(input logic b);
    @(negedge clk);
    sin = b;
    en  = 1'b1;
    @(posedge clk);
    #1;
    if (in_frame) if_high++;
  endtask

  task automatic send_bits(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(bits[i]);
  endtask

  task automatic idle(input int n, input bit chk_in_frame);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      en  = 1'b0;
      sin = ~sin;
      @(posedge clk);
      #1;
      if (chk_in_frame) check("in_frame_hold", int'(in_frame), 1);
    end
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] pl, input logic p,
                            input int gap_mid, input int gap_par);
    exp_t e;
    send_bits(16'b101100, 6);
    for (int i = DATA_W - 1; i >= 0; i--) begin
      send_bit(pl[i]);
      if (i == 3 && gap_mid > 0) idle(gap_mid, 1'b1);
    end
    if (gap_par > 0) idle(gap_par, 1'b1);
    e.good = ((^pl) == p);
    if (e.good) begin
      m_data = pl;
      m_cnt  = m_cnt + 1'b1;
    end
    e.d = m_data;
    e.c = m_cnt;
    q.push_back(e);
    send_bit(p);
    idle(1, 1'b0);
  endtask

  task automatic do_reset();
    check("no_missing_pulse", q.size(), 0);
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst    = 1'b0;
    m_data = '0;
    m_cnt  = '0;
    check("rst_data", int'(data), 0);
    check("rst_valid", int'(data_valid), 0);
    check("rst_perr", int'(parity_err), 0);
    check("rst_in_frame", int'(in_frame), 0);
    check("rst_frame_cnt", int'(frame_cnt), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    do_reset();

    // Good frame, in_frame must be high for exactly 7 sampled cycles
    if_high = 0;
    send_frame(6'b110010, 1'b1, 0, 0);
    check("in_frame_cycles", if_high, 7);
    check("in_frame_after", int'(in_frame), 0);

    // Bad parity after reset: data stays 0, count stays 0
    do_reset();
    send_frame(6'b110010, 1'b0, 0, 0);
    check("bad_par_data", int'(data), 0);
    check("bad_par_cnt", int'(frame_cnt), 0);

    // False lead-in followed by a real frame
    do_reset();
    send_bits(16'b1011, 4);
    send_frame(6'b000001, 1'b1, 0, 0);

    // en gating mid-payload and before parity
    do_reset();
    send_frame(6'b110010, 1'b1, 3, 2);
    check("gated_data", int'(data), 6'b110010);
    check("gated_cnt", int'(frame_cnt), 1);

    // Reset mid-frame, then a complete good frame
    do_reset();
    send_bits(16'b101100, 6);
    send_bits(16'b101, 3);
    do_reset();
    send_frame(6'b101010, 1'b1, 0, 0);
    check("post_abort_data", int'(data), 6'b101010);
    check("post_abort_cnt", int'(frame_cnt), 1);

    // Counter wrap over 256 good frames
    do_reset();
    for (int f = 1; f <= 256; f++) begin
      send_frame(6'b000000, 1'b0, 0, 0);
      if (f == 255) check("cnt_255", int'(frame_cnt), 255);
    end
    check("cnt_wrapped", int'(frame_cnt), 0);

    idle(3, 1'b0);
    check("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
